// File: rtl/fadd_s1.sv
// fadd_s1 -- alignment stage of the tensor-core fused multiply-add.
//
// Takes the multiplier's normalised product bundle and an FP22 addend. It
// resolves special operands, picks the larger-exponent operand as 'a', and
// right-aligns the other one ('b') with a sticky bit in bit 0. Results are
// registered through a two-entry skid buffer so ready_o comes from a flop.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   valid_i / ready_o    input handshake (ready_o registered)
//   prod_*_i             product sign, exponent, fraction and special flags
//   addend_i             FP22 addend {sign, exp, frac}
//   rm_i                 rounding mode (3'b010 = RDN), passed through to rm_o
//   valid_o / ready_i    output handshake
//   a_sign_o, b_sign_o   signs of the large / small operand
//   exp_o                common (larger) exponent
//   a_sig_o, b_sig_o     unshifted large significand, aligned small significand
//   eff_sub_o            a_sign ^ b_sign
//   special_valid_o      special_result_o is the final result
//   special_result_o     special-case result
//   fflags_o             {NV, DZ, OF, UF, NX}
//
// Skid buffer states
//   state | meaning
//   EMPTY | no entry held, outputs invalid
//   ONE   | main register M holds the output entry
//   TWO   | M holds the output, skid register S holds the next entry

`ifndef TC_EXPWIDTH
`define TC_EXPWIDTH 8
`endif
`ifndef TC_PRECISION
`define TC_PRECISION 14
`endif

module fadd_s1 #(
   parameter int EXPWIDTH  = `TC_EXPWIDTH,
   parameter int PRECISION = `TC_PRECISION
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic                          prod_sign_i,
   input  logic [EXPWIDTH-1:0]           prod_exp_i,
   input  logic [2*PRECISION-2:0]        prod_sig_i,
   input  logic                          prod_is_nan_i,
   input  logic                          prod_is_inf_i,
   input  logic                          prod_is_inv_i,
   input  logic                          prod_overflow_i,
   input  logic [EXPWIDTH+PRECISION-1:0] addend_i,
   input  logic [2:0]                    rm_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          a_sign_o,
   output logic                          b_sign_o,
   output logic [EXPWIDTH-1:0]           exp_o,
   output logic [2*PRECISION+2:0]        a_sig_o,
   output logic [2*PRECISION+2:0]        b_sig_o,
   output logic                          eff_sub_o,
   output logic                          special_valid_o,
   output logic [EXPWIDTH+PRECISION-1:0] special_result_o,
   output logic [4:0]                    fflags_o,
   output logic [2:0]                    rm_o
);

   localparam int AW = 2*PRECISION+3;
   localparam int FW = PRECISION-1;
   localparam int RW = EXPWIDTH+PRECISION;
   localparam logic [EXPWIDTH-1:0] AW_E = EXPWIDTH'(AW);
   localparam logic [2:0] RM_RDN = 3'b010;

   // ---------------------------------------------------------------- decode
   logic                c_sign;
   logic [EXPWIDTH-1:0] c_exp;
   logic [FW-1:0]       c_frac;
   logic                p_zero, c_zero, c_exp_max, c_nan, c_inf, p_inf;
   logic [AW-1:0]       p_sig, c_sig;

   assign c_sign    = addend_i[RW-1];
   assign c_exp     = addend_i[RW-2 -: EXPWIDTH];
   assign c_frac    = addend_i[FW-1:0];
   assign p_zero    = (prod_exp_i == '0);
   assign c_zero    = (c_exp == '0);
   assign c_exp_max = (c_exp == {EXPWIDTH{1'b1}});
   assign c_nan     = c_exp_max & (c_frac != '0);
   assign c_inf     = c_exp_max & (c_frac == '0);
   assign p_inf     = prod_is_inf_i | prod_overflow_i;

   // Zero exponents flush the whole significand, so a zero operand never
   // outranks a nonzero one in the exponent compare.
   assign p_sig = p_zero ? '0 : {1'b1, prod_sig_i, 3'b000};
   assign c_sig = c_zero ? '0 : {1'b1, c_frac, {PRECISION{1'b0}}, 3'b000};

   // ------------------------------------------------------------- alignment
   logic                prod_wins;
   logic                a_sign, b_sign;
   logic [EXPWIDTH-1:0] exp_a, exp_b, d;
   logic [AW-1:0]       a_sig, b_raw, b_lost, b_al;

   assign prod_wins = (prod_exp_i >= c_exp);
   assign a_sign    = prod_wins ? prod_sign_i : c_sign;
   assign b_sign    = prod_wins ? c_sign      : prod_sign_i;
   assign exp_a     = prod_wins ? prod_exp_i  : c_exp;
   assign exp_b     = prod_wins ? c_exp       : prod_exp_i;
   assign a_sig     = prod_wins ? p_sig       : c_sig;
   assign b_raw     = prod_wins ? c_sig       : p_sig;
   assign d         = exp_a - exp_b;

   always_comb begin
      b_lost = '0;
      b_al   = '0;
      if (d >= AW_E) begin
         b_al = {{(AW-1){1'b0}}, |b_raw};
      end else begin
         b_lost = b_raw & ~({AW{1'b1}} << d);
         b_al   = (b_raw >> d) | {{(AW-1){1'b0}}, |b_lost};
      end
   end

   // --------------------------------------------------------- special cases
   localparam logic [RW-1:0] QNAN = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(FW-1){1'b0}}};

   logic          sp_valid;
   logic [RW-1:0] sp_result;
   logic [4:0]    sp_flags;
   logic          zero_sign;

   assign zero_sign = (rm_i == RM_RDN) ? (prod_sign_i | c_sign) : (prod_sign_i & c_sign);

   always_comb begin
      sp_valid  = 1'b0;
      sp_result = '0;
      sp_flags  = '0;
      if (prod_is_nan_i | c_nan) begin
         sp_valid    = 1'b1;
         sp_result   = QNAN;
         sp_flags[4] = prod_is_inv_i;
      end else if (p_inf & c_inf & (prod_sign_i ^ c_sign)) begin
         sp_valid    = 1'b1;
         sp_result   = QNAN;
         sp_flags[4] = 1'b1;
      end else if (p_inf | c_inf) begin
         sp_valid    = 1'b1;
         sp_result   = {(p_inf ? prod_sign_i : c_sign), {EXPWIDTH{1'b1}}, {FW{1'b0}}};
         sp_flags[2] = prod_overflow_i;
      end else if (p_zero & c_zero) begin
         sp_valid  = 1'b1;
         sp_result = {zero_sign, {(RW-1){1'b0}}};
      end
   end

   // ----------------------------------------------------------- skid buffer
   typedef struct packed {
      logic                a_sign;
      logic                b_sign;
      logic [EXPWIDTH-1:0] exp;
      logic [AW-1:0]       a_sig;
      logic [AW-1:0]       b_sig;
      logic                eff_sub;
      logic                sp_valid;
      logic [RW-1:0]       sp_result;
      logic [4:0]          flags;
      logic [2:0]          rm;
   } entry_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   entry_t din, m_q, s_q;
   state_t state_q, state_d;
   logic   accept, drain, ld_m_new, ld_m_skid, ld_s;

   assign din = '{a_sign:    a_sign,
                  b_sign:    b_sign,
                  exp:       exp_a,
                  a_sig:     a_sig,
                  b_sig:     b_al,
                  eff_sub:   a_sign ^ b_sign,
                  sp_valid:  sp_valid,
                  sp_result: sp_result,
                  flags:     sp_flags,
                  rm:        rm_i};

   assign valid_o = (state_q != EMPTY);
   assign accept  = valid_i & ready_o;
   assign drain   = valid_o & ready_i;

   always_comb begin
      state_d   = state_q;
      ld_m_new  = 1'b0;
      ld_m_skid = 1'b0;
      ld_s      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               ld_m_new = 1'b1;
               state_d  = ONE;
            end
         end
         ONE: begin
            if (accept & drain) begin
               ld_m_new = 1'b1;
            end else if (accept) begin
               ld_s    = 1'b1;
               state_d = TWO;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (drain) begin
               ld_m_skid = 1'b1;
               state_d   = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         ready_o <= 1'b1;
         m_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         ready_o <= (state_d != TWO);
         if (ld_m_new) begin
            m_q <= din;
         end else if (ld_m_skid) begin
            m_q <= s_q;
         end
         if (ld_s) begin
            s_q <= din;
         end
      end
   end

   assign a_sign_o         = m_q.a_sign;
   assign b_sign_o         = m_q.b_sign;
   assign exp_o            = m_q.exp;
   assign a_sig_o          = m_q.a_sig;
   assign b_sig_o          = m_q.b_sig;
   assign eff_sub_o        = m_q.eff_sub;
   assign special_valid_o  = m_q.sp_valid;
   assign special_result_o = m_q.sp_result;
   assign fflags_o         = m_q.flags;
   assign rm_o             = m_q.rm;

endmodule
